// File: rtl/chrono_counter_hms.sv
// rtl/chrono_counter_hms.sv - HH:MM:SS BCD stopwatch/countdown timer with pause, auto-reload and expiry flags
// Optional lap capture is built when LAP_CAPTURE_EN is defined.
module chrono_counter_hms #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int MAX_HOURS = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        start,
    input  logic        clear,
    input  logic        load,
    input  logic        auto_reload,
    input  logic [23:0] load_bcd,
    input  logic        lap,
    output logic [23:0] time_bcd,
    output logic        tick,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        wrap,
    output logic [23:0] lap_bcd,
    output logic        lap_valid
);

    localparam int              PW         = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   C_PRESC_TC = PW'(CLK_FREQ - 1);
    localparam logic [3:0]      C_MAXH_T   = 4'(MAX_HOURS / 10);
    localparam logic [3:0]      C_MAXH_O   = 4'(MAX_HOURS % 10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_time;
    logic [23:0]   r_reload;
    logic          r_tick;
    logic          r_done;
    logic          r_wrap;
    logic          r_expired;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Prescaler advances on the cycle that enters RUN, so n seconds take n*CLK_FREQ start cycles.
    logic w_cnt_en;
    logic w_tc;
    logic w_is_zero;
    logic w_is_one;
    logic w_expire_stop;

    assign w_cnt_en      = start && (r_state != S_EXPIRED);
    assign w_tc          = w_cnt_en && (r_presc == C_PRESC_TC);
    assign w_is_zero     = (r_time == 24'h000000);
    assign w_is_one      = (r_time == 24'h000001);
    assign w_expire_stop = w_tc && mode && !auto_reload && (w_is_zero || w_is_one);

    logic [3:0] w_so, w_st, w_mo, w_mt, w_ho, w_ht;
    assign {w_ht, w_ho, w_mt, w_mo, w_st, w_so} = r_time;

    logic [3:0] w_ld_so, w_ld_st, w_ld_mo, w_ld_mt, w_ld_ho, w_ld_ht;
    logic [7:0] w_ld_hr;
    logic [23:0] w_ld_time;

    assign w_ld_so   = clamp_digit(load_bcd[3:0],   4'd9);
    assign w_ld_st   = clamp_digit(load_bcd[7:4],   4'd5);
    assign w_ld_mo   = clamp_digit(load_bcd[11:8],  4'd9);
    assign w_ld_mt   = clamp_digit(load_bcd[15:12], 4'd5);
    assign w_ld_ho   = clamp_digit(load_bcd[19:16], 4'd9);
    assign w_ld_ht   = clamp_digit(load_bcd[23:20], 4'd9);
    // Digits are already valid BCD here, so a packed compare orders hours correctly.
    assign w_ld_hr   = ({w_ld_ht, w_ld_ho} > {C_MAXH_T, C_MAXH_O}) ? {C_MAXH_T, C_MAXH_O}
                                                                  : {w_ld_ht, w_ld_ho};
    assign w_ld_time = {w_ld_hr, w_ld_mt, w_ld_mo, w_ld_st, w_ld_so};

    logic        w_c_so, w_c_st, w_c_mo, w_c_mt;
    logic        w_up_wrap;
    logic [7:0]  w_up_hr;
    logic [23:0] w_up_time;

    assign w_c_so    = (w_so == 4'd9);
    assign w_c_st    = w_c_so && (w_st == 4'd5);
    assign w_c_mo    = w_c_st && (w_mo == 4'd9);
    assign w_c_mt    = w_c_mo && (w_mt == 4'd5);
    assign w_up_wrap = w_c_mt && ({w_ht, w_ho} == {C_MAXH_T, C_MAXH_O});

    always_comb begin
        w_up_hr = {w_ht, w_ho};
        if (w_up_wrap) begin
            w_up_hr = 8'h00;
        end else if (w_c_mt) begin
            w_up_hr = (w_ho == 4'd9) ? {w_ht + 4'd1, 4'd0} : {w_ht, w_ho + 4'd1};
        end
    end

    assign w_up_time = {
        w_up_hr,
        w_c_mo ? ((w_mt == 4'd5) ? 4'd0 : w_mt + 4'd1) : w_mt,
        w_c_st ? ((w_mo == 4'd9) ? 4'd0 : w_mo + 4'd1) : w_mo,
        w_c_so ? ((w_st == 4'd5) ? 4'd0 : w_st + 4'd1) : w_st,
        w_c_so ? 4'd0 : w_so + 4'd1
    };

    logic        w_b_so, w_b_st, w_b_mo, w_b_mt;
    logic [7:0]  w_dn_hr;
    logic [23:0] w_dn_time;

    assign w_b_so = (w_so == 4'd0);
    assign w_b_st = w_b_so && (w_st == 4'd0);
    assign w_b_mo = w_b_st && (w_mo == 4'd0);
    assign w_b_mt = w_b_mo && (w_mt == 4'd0);

    always_comb begin
        w_dn_hr = {w_ht, w_ho};
        if (w_b_mt) begin
            w_dn_hr = (w_ho == 4'd0) ? {w_ht - 4'd1, 4'd9} : {w_ht, w_ho - 4'd1};
        end
    end

    assign w_dn_time = {
        w_dn_hr,
        w_b_mo ? ((w_mt == 4'd0) ? 4'd5 : w_mt - 4'd1) : w_mt,
        w_b_st ? ((w_mo == 4'd0) ? 4'd9 : w_mo - 4'd1) : w_mo,
        w_b_so ? ((w_st == 4'd0) ? 4'd5 : w_st - 4'd1) : w_st,
        w_b_so ? 4'd9 : w_so - 4'd1
    };

    // A terminal count held across a pause fires on the resume edge, so expiry is checked there too.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (load) begin
            if (r_state == S_EXPIRED) begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (start) begin
                        w_state_nxt = w_expire_stop ? S_EXPIRED : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!start) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_expire_stop) begin
                        w_state_nxt = S_EXPIRED;
                    end
                end
                S_EXPIRED: w_state_nxt = S_EXPIRED;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_time    <= 24'h000000;
            r_reload  <= 24'h000000;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            if (clear) begin
                r_time    <= 24'h000000;
                r_presc   <= '0;
                r_expired <= 1'b0;
            end else if (load) begin
                r_time    <= w_ld_time;
                r_reload  <= w_ld_time;
                r_presc   <= '0;
                r_expired <= 1'b0;
            end else if (w_tc) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
                if (!mode) begin
                    r_time <= w_up_time;
                    r_wrap <= w_up_wrap;
                end else if (w_is_zero) begin
                    // Sitting at zero: reload if enabled; a zero reload value expires again.
                    if (auto_reload) begin
                        r_time <= r_reload;
                    end
                    if (!auto_reload || (r_reload == 24'h000000)) begin
                        r_done    <= 1'b1;
                        r_expired <= 1'b1;
                    end
                end else begin
                    r_time <= w_dn_time;
                    if (w_is_one) begin
                        r_done    <= 1'b1;
                        r_expired <= 1'b1;
                    end
                end
            end else if (w_cnt_en) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign time_bcd = r_time;
    assign tick     = r_tick;
    assign running  = (r_state == S_RUN);
    assign done     = r_done;
    assign expired  = r_expired;
    assign wrap     = r_wrap;

`ifdef LAP_CAPTURE_EN
    logic [23:0] r_lap_bcd;
    logic        r_lap_valid;

    // Captures the pre-update value when a tick lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lap_bcd   <= 24'h000000;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_bcd   <= 24'h000000;
            r_lap_valid <= 1'b0;
        end else begin
            r_lap_valid <= lap;
            if (lap) begin
                r_lap_bcd <= r_time;
            end
        end
    end

    assign lap_bcd   = r_lap_bcd;
    assign lap_valid = r_lap_valid;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign lap_bcd      = 24'h000000;
    assign lap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_chrono_counter_hms.sv
// tb/tb_chrono_counter_hms.sv - randomized and directed bench for chrono_counter_hms against a seconds-based model
module tb_chrono_counter_hms;

    localparam int CF   = 10;
    localparam int MAXH = 23;
    localparam int DAY  = (MAXH + 1) * 3600;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_EXP  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        auto_reload = 1'b0;
    logic [23:0] load_bcd = 24'h0;
    logic        lap = 1'b0;
    logic [23:0] time_bcd;
    logic        tick;
    logic        running;
    logic        done;
    logic        expired;
    logic        wrap;
    logic [23:0] lap_bcd;
    logic        lap_valid;

    int errors = 0;
    int checks = 0;

    int          m_secs = 0;
    int          m_reload = 0;
    int          m_presc = 0;
    int          m_state = ST_IDLE;
    bit          m_tick, m_done, m_wrap, m_expired, m_lap_valid;
    logic [23:0] m_lap_bcd = 24'h0;

    chrono_counter_hms #(.CLK_FREQ(CF), .MAX_HOURS(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .clear(clear),
        .load(load), .auto_reload(auto_reload), .load_bcd(load_bcd), .lap(lap),
        .time_bcd(time_bcd), .tick(tick), .running(running), .done(done),
        .expired(expired), .wrap(wrap), .lap_bcd(lap_bcd), .lap_valid(lap_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    function automatic int clamp_secs(input logic [23:0] v);
        int h, m, s;
        h = lim(int'(v[23:20]), 9) * 10 + lim(int'(v[19:16]), 9);
        h = lim(h, MAXH);
        m = lim(int'(v[15:12]), 5) * 10 + lim(int'(v[11:8]), 9);
        s = lim(int'(v[7:4]), 5) * 10 + lim(int'(v[3:0]), 9);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [53:0] dut_vec();
        return {time_bcd, tick, running, done, expired, wrap, lap_bcd, lap_valid};
    endfunction

    function automatic logic [53:0] mdl_vec();
        return {to_bcd(m_secs), m_tick, (m_state == ST_RUN), m_done, m_expired, m_wrap,
                m_lap_bcd, m_lap_valid};
    endfunction

    task automatic expire_evt(input bit stop);
        m_done    = 1'b1;
        m_expired = 1'b1;
        if (stop) m_state = ST_EXP;
    endtask

    task automatic model_second();
        if (!mode) begin
            m_secs = (m_secs + 1) % DAY;
            m_wrap = (m_secs == 0);
        end else if (m_secs > 1) begin
            m_secs--;
        end else if (m_secs == 1) begin
            m_secs = 0;
            expire_evt(!auto_reload);
        end else if (auto_reload) begin
            m_secs = m_reload;
            if (m_reload == 0) expire_evt(1'b0);
        end else begin
            expire_evt(1'b1);
        end
    endtask

    task automatic model_edge();
        bit cnt;
        m_tick = 0; m_done = 0; m_wrap = 0; m_lap_valid = 0;
        if (!rst_n) begin
            m_secs = 0; m_reload = 0; m_presc = 0; m_state = ST_IDLE;
            m_expired = 0; m_lap_bcd = 24'h0;
            return;
        end
`ifdef LAP_CAPTURE_EN
        if (lap && !clear) begin
            m_lap_bcd   = to_bcd(m_secs);
            m_lap_valid = 1'b1;
        end
`endif
        if (clear) begin
            m_secs = 0; m_presc = 0; m_expired = 0; m_state = ST_IDLE; m_lap_bcd = 24'h0;
        end else if (load) begin
            m_secs = clamp_secs(load_bcd);
            m_reload = m_secs;
            m_presc = 0;
            m_expired = 0;
            if (m_state == ST_EXP) m_state = ST_IDLE;
        end else begin
            cnt = start && (m_state != ST_EXP);
            if (start && (m_state == ST_IDLE || m_state == ST_PAUSE)) m_state = ST_RUN;
            else if (!start && m_state == ST_RUN) m_state = ST_PAUSE;
            if (cnt) begin
                if (m_presc == CF - 1) begin
                    m_presc = 0;
                    m_tick = 1'b1;
                    model_second();
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; start = 1'b0; load = 1'b0; lap = 1'b0;
        cyc();
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] v);
        load = 1'b1; load_bcd = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        if (dut_vec() !== 54'h0) begin
            errors++;
            $display("FAIL reset_zero got=%h want=%h", dut_vec(), 54'h0);
        end
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset_model got=%h want=%h", dut_vec(), mdl_vec());
        end
        checks++;
        rst_n = 1'b1;
    endtask

    task automatic test_up_run();
        int ticks = 0;
        mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            cyc();
            if (tick) ticks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL up_run cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
            end
            checks++;
        end
        if (ticks != 60) begin
            errors++;
            $display("FAIL up_run_ticks got=%0d want=60", ticks);
        end
        checks++;
        if (time_bcd !== 24'h000100) begin
            errors++;
            $display("FAIL up_run_time got=%h want=000100", time_bcd);
        end
        checks++;
    endtask

    task automatic test_up_wrap();
        do_clear();
        mode = 1'b0;
        do_load(24'h235959);
        start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 10 && (time_bcd !== 24'h000000 || wrap !== 1'b1)) begin
                errors++;
                $display("FAIL up_wrap_edge time=%h wrap=%b want 000000/1", time_bcd, wrap);
            end
            if (i == 10) checks++;
            if (i != 10 && wrap !== 1'b0) begin
                errors++;
                $display("FAIL up_wrap_pulse cyc=%0d wrap=%b want 0", i, wrap);
            end
            if (i != 10) checks++;
        end
    endtask

    task automatic test_down_expiry();
        int done_at = -1;
        do_clear();
        mode = 1'b1; auto_reload = 1'b0;
        do_load(24'h000002);
        start = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            cyc();
            if (done && done_at < 0) done_at = i;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL down cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
            end
            checks++;
        end
        if (done_at != 20) begin
            errors++;
            $display("FAIL down_done_cycle got=%0d want=20", done_at);
        end
        checks++;
        if ({expired, running, time_bcd} !== {1'b1, 1'b0, 24'h000000}) begin
            errors++;
            $display("FAIL down_final exp=%b run=%b time=%h want 1/0/000000", expired, running, time_bcd);
        end
        checks++;
    endtask

    task automatic test_auto_reload();
        int dq[$];
        do_clear();
        mode = 1'b1; auto_reload = 1'b1;
        do_load(24'h000003);
        start = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            cyc();
            if (done) dq.push_back(i);
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL reload cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
            end
            checks++;
        end
        if (dq.size() != 3) begin
            errors++;
            $display("FAIL reload_count got=%0d want=3", dq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (dq[k] != 30 + 40 * k) begin
                    errors++;
                    $display("FAIL reload_when idx=%0d got=%0d want=%0d", k, dq[k], 30 + 40 * k);
                end
                checks++;
            end
        end
        checks++;
        auto_reload = 1'b0;
    endtask

    task automatic test_pause_clamp();
        int gap = -1;
        do_clear();
        mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 15; i++) cyc();
        start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_tick cyc=%0d tick=%b want 0", i, tick);
            end
            checks++;
        end
        start = 1'b1;
        for (int i = 1; i <= 20 && gap < 0; i++) begin
            cyc();
            if (tick) gap = i;
        end
        if (gap != 5 || time_bcd !== 24'h000002) begin
            errors++;
            $display("FAIL pause_resume gap=%0d time=%h want 5/000002", gap, time_bcd);
        end
        checks++;
        start = 1'b0;
        do_load(24'hFF7FFF);
        if (time_bcd !== 24'h235959) begin
            errors++;
            $display("FAIL load_clamp got=%h want=235959", time_bcd);
        end
        checks++;
        do_load(24'h3A6C5B);
        if (time_bcd !== to_bcd(clamp_secs(24'h3A6C5B))) begin
            errors++;
            $display("FAIL load_clamp2 got=%h want=%h", time_bcd, to_bcd(clamp_secs(24'h3A6C5B)));
        end
        checks++;
    endtask

    task automatic test_lap();
        do_clear();
        mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 79; i++) cyc();
        lap = 1'b1;
        cyc();
        lap = 1'b0;
`ifdef LAP_CAPTURE_EN
        if ({lap_bcd, lap_valid, time_bcd, tick} !== {24'h000007, 1'b1, 24'h000008, 1'b1}) begin
            errors++;
            $display("FAIL lap_capture lap=%h v=%b time=%h tick=%b want 000007/1/000008/1",
                     lap_bcd, lap_valid, time_bcd, tick);
        end
        checks++;
        cyc();
        if (lap_valid !== 1'b0 || lap_bcd !== 24'h000007) begin
            errors++;
            $display("FAIL lap_hold v=%b lap=%h want 0/000007", lap_valid, lap_bcd);
        end
        checks++;
        do_clear();
        if (lap_bcd !== 24'h000000) begin
            errors++;
            $display("FAIL lap_clear got=%h want=000000", lap_bcd);
        end
        checks++;
`else
        if ({lap_bcd, lap_valid} !== 25'h0 || time_bcd !== 24'h000008) begin
            errors++;
            $display("FAIL lap_off lap=%h v=%b time=%h want 0/0/000008", lap_bcd, lap_valid, time_bcd);
        end
        checks++;
`endif
    endtask

    task automatic test_back_to_back();
        do_clear();
        mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 9; i++) cyc();
        do_load(24'h000100);
        if (tick !== 1'b0 || time_bcd !== 24'h000100 || running !== 1'b1) begin
            errors++;
            $display("FAIL load_tick tick=%b time=%h run=%b want 0/000100/1", tick, time_bcd, running);
        end
        checks++;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) mode = 1'b1;
            cyc();
        end
        if (tick !== 1'b1 || time_bcd !== 24'h000059) begin
            errors++;
            $display("FAIL mode_switch tick=%b time=%h want 1/000059", tick, time_bcd);
        end
        checks++;
        for (int i = 1; i <= 5; i++) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        if ({time_bcd, running, done, wrap, tick} !== {24'h000000, 4'b0000}) begin
            errors++;
            $display("FAIL clear_run time=%h run=%b done=%b wrap=%b tick=%b want zeros",
                     time_bcd, running, done, wrap, tick);
        end
        checks++;
        mode = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int i = 1; i <= 6000; i++) begin
            r = int'($urandom_range(0, 999));
            rst_n = (r >= 3);
            clear = (r >= 3 && r < 10);
            load  = (r >= 10 && r < 30);
            if ($urandom_range(0, 39) == 0) start = ~start;
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            if ($urandom_range(0, 149) == 0) auto_reload = ~auto_reload;
            case ($urandom_range(0, 3))
                0: load_bcd = to_bcd(int'($urandom_range(0, 4)));
                1: load_bcd = 24'h235958;
                2: load_bcd = 24'h095959;
                default: load_bcd = 24'($urandom());
            endcase
            lap = ($urandom_range(0, 15) == 0);
            cyc();
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
            end
            checks++;
        end
        rst_n = 1'b1; clear = 1'b0; load = 1'b0; lap = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_up_run();
        test_up_wrap();
        test_down_expiry();
        test_auto_reload();
        test_pause_clamp();
        test_lap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
